// File: rtl/ram_arb_pkg.sv
// Shared constants, FSM state type and helpers for the RAM arbiter.
package ram_arb_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;

  // Wide enough to count up to the largest legal MAX_LOCK (15).
  localparam int LOCK_CNT_W = 4;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Index of the requester after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ram_arb_rr_pick.sv
// One-hot priority picker: the first requester with i_req set, searching
// upward from i_ptr and wrapping. A pointer tied to 0 gives fixed priority.
module rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]          i_req,
  input  logic [$clog2(NREQ)-1:0]  i_ptr,
  output logic [NREQ-1:0]          o_gnt
);

  logic w_found;

  // Scan offsets 0..NREQ-1 from the pointer; the smallest offset wins.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && i_req[i] && (i == ((int'(i_ptr) + k) % NREQ))) begin
          o_gnt[i] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ram_arb.sv
// Round-robin arbiter sharing one 64x8 single-port synchronous RAM among
// NREQ requesters, with an optional per-requester lock for back-to-back
// accesses (e.g. read-modify-write) capped at MAX_LOCK grants.
// Build option: RAM_ARB_FIXED_PRIO_EN ties the search pointer to 0 so the
// lowest index always wins in ARB; lock behaviour is unchanged.
//
// Handshake: a requester raises req[i] with its command and holds it until
// gnt[i]; gnt[i] is combinational and means the command is accepted in
// that same cycle. Reads answer with a one-cycle rvalid[i] pulse two
// cycles after the grant, with data on the shared rdata. Writes have no
// response.
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int MAX_LOCK = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NREQ-1:0]          i_req,
  input  logic [NREQ-1:0]          i_wr,
  input  logic [NREQ-1:0]          i_lock,
  input  logic [NREQ*ADDR_W-1:0]   i_addr,
  input  logic [NREQ*DATA_W-1:0]   i_din,
  output logic [NREQ-1:0]          o_gnt,
  output logic [NREQ-1:0]          o_rvalid,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_ram_wr,
  output logic [ADDR_W-1:0]        o_ram_addr,
  output logic [DATA_W-1:0]        o_ram_din,
  input  logic [DATA_W-1:0]        i_ram_dout,
  output logic                     o_dbg_state,
  output logic [$clog2(NREQ)-1:0]  o_dbg_ptr,
  output logic [LOCK_CNT_W-1:0]    o_dbg_lock_cnt
);

  localparam int PTR_W = $clog2(NREQ);

  // Arbitration state
  arb_state_e             r_state;
  arb_state_e             w_state_nxt;
  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       w_ptr_nxt;
  logic [PTR_W-1:0]       r_owner;
  logic [PTR_W-1:0]       w_owner_nxt;
  logic [LOCK_CNT_W-1:0]  r_lock_cnt;
  logic [LOCK_CNT_W-1:0]  w_lock_cnt_nxt;
  logic [LOCK_CNT_W-1:0]  w_lock_cnt_inc;

  // Grant selection
  logic [NREQ-1:0]        w_pick;
  logic [PTR_W-1:0]       w_pick_idx;
  logic                   w_pick_lock;
  logic                   w_own_req;
  logic                   w_own_lock;
  logic                   w_any;
  logic [PTR_W-1:0]       w_sel_idx;

  // RAM command
  logic [NREQ-1:0]        w_gnt;
  logic                   w_ram_wr;
  logic [ADDR_W-1:0]      w_ram_addr;
  logic [DATA_W-1:0]      w_ram_din;

  // Read return pipeline
  logic                   r_s1_vld;
  logic [PTR_W-1:0]       r_s1_own;
  logic [NREQ-1:0]        w_rvalid_nxt;
  logic [NREQ-1:0]        r_rvalid;
  logic [DATA_W-1:0]      r_rdata;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick)
  );

  // Index and lock bit of the picked requester; req/lock of the lock owner.
  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick[i]) w_pick_idx = PTR_W'(i);
    end
    w_pick_lock    = |(w_pick & i_lock);
    w_own_req      = i_req[r_owner];
    w_own_lock     = i_lock[r_owner];
    w_lock_cnt_inc = r_lock_cnt + LOCK_CNT_W'(1);
  end

  // Next-state logic: who is granted this cycle and how ptr/lock evolve.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_owner_nxt    = r_owner;
    w_lock_cnt_nxt = r_lock_cnt;
    w_any          = 1'b0;
    w_sel_idx      = r_owner;
    if (!i_rst) begin
      case (r_state)
        ARB: begin
          if (|w_pick) begin
            w_any     = 1'b1;
            w_sel_idx = w_pick_idx;
            w_ptr_nxt = PTR_W'(wrap_inc(int'(w_pick_idx), NREQ));
            if (w_pick_lock && (MAX_LOCK > 1)) begin
              w_state_nxt    = LOCKED;
              w_owner_nxt    = w_pick_idx;
              w_lock_cnt_nxt = LOCK_CNT_W'(1);
            end
          end
        end
        LOCKED: begin
          if (w_own_req) begin
            w_any     = 1'b1;
            w_sel_idx = r_owner;
            if (!w_own_lock || (w_lock_cnt_inc == LOCK_CNT_W'(MAX_LOCK))) begin
              w_state_nxt    = ARB;
              w_ptr_nxt      = PTR_W'(wrap_inc(int'(r_owner), NREQ));
              w_lock_cnt_nxt = '0;
            end else begin
              w_lock_cnt_nxt = w_lock_cnt_inc;
            end
          end else begin
            // Owner dropped its request: nobody is granted, release the lock.
            w_state_nxt    = ARB;
            w_ptr_nxt      = PTR_W'(wrap_inc(int'(r_owner), NREQ));
            w_lock_cnt_nxt = '0;
          end
        end
        default: w_state_nxt = ARB;
      endcase
    end
`ifdef RAM_ARB_FIXED_PRIO_EN
    w_ptr_nxt = '0;
`endif
  end

  // Arbitration state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ARB;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  // Route the granted requester's command to the RAM; idle reads address 0.
  always_comb begin
    w_gnt      = '0;
    w_ram_wr   = 1'b0;
    w_ram_addr = '0;
    w_ram_din  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_any && (i == int'(w_sel_idx))) begin
        w_gnt[i]   = 1'b1;
        w_ram_wr   = i_wr[i];
        w_ram_addr = i_addr[i*ADDR_W +: ADDR_W];
        w_ram_din  = i_din[i*DATA_W +: DATA_W];
      end
    end
  end

  // Decode the stage-1 owner into the one-hot rvalid for the next edge.
  always_comb begin
    w_rvalid_nxt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_s1_vld && (i == int'(r_s1_own))) w_rvalid_nxt[i] = 1'b1;
    end
  end

  // Read return: stage 1 tracks the RAM access, stage 2 captures its data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_vld <= 1'b0;
      r_s1_own <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_s1_vld <= w_any & ~w_ram_wr;
      r_s1_own <= w_sel_idx;
      r_rvalid <= w_rvalid_nxt;
      if (r_s1_vld) r_rdata <= i_ram_dout;
    end
  end

  assign o_gnt          = w_gnt;
  assign o_ram_wr       = w_ram_wr;
  assign o_ram_addr     = w_ram_addr;
  assign o_ram_din      = w_ram_din;
  assign o_rvalid       = r_rvalid;
  assign o_rdata        = r_rdata;
  assign o_dbg_state    = (r_state == LOCKED);
  assign o_dbg_ptr      = r_ptr;
  assign o_dbg_lock_cnt = r_lock_cnt;

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb (NREQ=2, MAX_LOCK=4) with a behavioural RAM, a
// rule-level arbitration model and an expected-read scoreboard.
module tb_ram_arb;

  localparam int NREQ     = 2;
  localparam int MAX_LOCK = 4;
`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req = '0, wr = '0, lock = '0;
  logic [NREQ*6-1:0] addr = '0;
  logic [NREQ*8-1:0] din = '0;
  logic [NREQ-1:0]   gnt, rvalid;
  logic [7:0]        rdata, ram_din, ram_dout;
  logic              ram_wr;
  logic [5:0]        ram_addr;
  logic              dbg_state;
  logic [0:0]        dbg_ptr;
  logic [3:0]        dbg_lock_cnt;

  ram_arb #(.NREQ(NREQ), .MAX_LOCK(MAX_LOCK)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_wr(wr), .i_lock(lock),
    .i_addr(addr), .i_din(din), .o_gnt(gnt), .o_rvalid(rvalid),
    .o_rdata(rdata), .o_ram_wr(ram_wr), .o_ram_addr(ram_addr),
    .o_ram_din(ram_din), .i_ram_dout(ram_dout), .o_dbg_state(dbg_state),
    .o_dbg_ptr(dbg_ptr), .o_dbg_lock_cnt(dbg_lock_cnt)
  );

  // Behavioural single-port synchronous RAM
  logic [7:0] ram [64];
  always @(posedge clk) begin
    if (ram_wr) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  // Scoreboard and reference model
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         exp_due_q[$];
  int         exp_own_q[$];
  logic [7:0] m_mem [64];
  logic [7:0] m_rdata;
  int         m_ptr, m_owner, m_run;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic bit_of(input logic [NREQ-1:0] v, input int i);
    logic [NREQ-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // Returns the requester the rules grant this cycle (-1: none) and
  // advances pointer/lock bookkeeping.
  function automatic int model_grant(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l);
    int g;
    int start;
    g = -1;
    if (m_owner >= 0) begin
      if (bit_of(r, m_owner)) begin
        g = m_owner;
        m_run++;
        if (!bit_of(l, m_owner) || m_run >= MAX_LOCK) begin
          m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_run = 0;
        end
      end else begin
        m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_run = 0;
      end
    end else begin
      start = FIXED ? 0 : m_ptr;
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && bit_of(r, (start + k) % NREQ)) g = (start + k) % NREQ;
      if (g >= 0) begin
        m_ptr = (g + 1) % NREQ;
        if (bit_of(l, g) && MAX_LOCK > 1) begin m_owner = g; m_run = 1; end
      end
    end
    return g;
  endfunction

  // Driver: one clock cycle of stimulus, checked against the model.
  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w,
                      input logic [NREQ-1:0] l, input logic [11:0] a,
                      input logic [15:0] d, output logic [NREQ-1:0] g_obs);
    int g, own;
    logic [5:0] ea;
    logic [7:0] ed;
    logic [31:0] exp_rv;
    req = r; wr = w; lock = l; addr = a; din = d;
    #1;
    g_obs = gnt;
    exp_rv = 0;
    if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
      void'(exp_due_q.pop_front());
      own = exp_own_q.pop_front();
      m_rdata = exp_q.pop_front();
      exp_rv = 32'(1) << own;
    end
    chk("rvalid", 32'(rvalid), exp_rv);
    chk("rdata", 32'(rdata), 32'(m_rdata));
    g = model_grant(r, l);
    if (g < 0) begin
      chk("gnt_none", 32'(gnt), 0);
      chk("ram_wr_idle", 32'(ram_wr), 0);
      chk("ram_addr_idle", 32'(ram_addr), 0);
    end else begin
      ea = 6'(a >> (6 * g));
      ed = 8'(d >> (8 * g));
      chk("gnt", 32'(gnt), 32'(1) << g);
      chk("ram_wr", 32'(ram_wr), 32'(bit_of(w, g)));
      chk("ram_addr", 32'(ram_addr), 32'(ea));
      if (bit_of(w, g)) begin
        chk("ram_din", 32'(ram_din), 32'(ed));
        m_mem[ea] = ed;
      end else begin
        exp_due_q.push_back(cyc + 2);
        exp_own_q.push_back(g);
        exp_q.push_back(m_mem[ea]);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  // One reset cycle with requests r held high; checks outputs during and after.
  task automatic do_reset(input logic [NREQ-1:0] r);
    rst = 1'b1; req = r; wr = '1; lock = '0; addr = 12'hFFF; din = 16'h5A5A;
    #1;
    chk("gnt_in_rst", 32'(gnt), 0);
    chk("ram_wr_in_rst", 32'(ram_wr), 0);
    m_ptr = 0; m_owner = -1; m_run = 0; m_rdata = 8'h00;
    exp_q.delete(); exp_due_q.delete(); exp_own_q.delete();
    @(negedge clk);
    cyc++;
    rst = 1'b0; req = '0; wr = '0; lock = '0;
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_ptr", 32'(dbg_ptr), 0);
    chk("rst_state", 32'(dbg_state), 0);
    chk("rst_lock_cnt", 32'(dbg_lock_cnt), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] r_rnd;
    int exp_g;
    m_ptr = 0; m_owner = -1; m_run = 0; m_rdata = 8'h00;
    @(negedge clk);
    do_reset('0);

    // Fill RAM through the arbiter so every later read is defined.
    for (int a = 0; a < 64; a++)
      step(NREQ'(1) << (a % 2), '1, '0, {6'(a), 6'(a)}, 16'($urandom), g);

    // Single write then read by requester 0.
    step(2'b01, 2'b01, 2'b00, {6'd0, 6'd10}, {8'h00, 8'hA5}, g);
    step(2'b01, 2'b00, 2'b00, {6'd0, 6'd10}, 16'h0000, g);
    step(2'b00, 2'b00, 2'b00, 12'h000, 16'h0000, g);
    chk("single_rvalid", 32'(rvalid), 32'h1);
    chk("single_rdata", 32'(rdata), 32'hA5);

    // Contention: both requesters, no lock.
    do_reset('0);
    for (int k = 0; k < 6; k++) begin
      step(2'b11, 2'b00, 2'b00, 12'($urandom), 16'($urandom), g);
      exp_g = FIXED ? 1 : ((k % 2 == 0) ? 1 : 2);
      chk("contend_gnt", 32'(g), 32'(exp_g));
    end

    // Lock cap: requester 1 holds lock while requester 0 waits.
    do_reset('0);
    for (int k = 0; k < 5; k++) begin
      step((k == 0) ? 2'b10 : 2'b11, 2'b00, 2'b10, 12'($urandom), 16'($urandom), g);
      chk("lock_gnt", 32'(g), (k < 4) ? 32'h2 : 32'h1);
      if (k == 0) begin
        chk("lock_state", 32'(dbg_state), 32'h1);
        chk("lock_cnt", 32'(dbg_lock_cnt), 32'h1);
      end
    end

    // Write then immediate read of the same address.
    step(2'b10, 2'b10, 2'b00, {6'd63, 6'd0}, {8'h3C, 8'h00}, g);
    step(2'b10, 2'b00, 2'b00, {6'd63, 6'd0}, 16'h0000, g);
    step(2'b00, 2'b00, 2'b00, 12'h000, 16'h0000, g);
    chk("hazard_rvalid", 32'(rvalid), 32'h2);
    chk("hazard_rdata", 32'(rdata), 32'h3C);

    // Reset in the cycle after a read grant drops the read.
    step(2'b01, 2'b00, 2'b00, {6'd0, 6'd10}, 16'h0000, g);
    do_reset(2'b11);
    step(2'b00, 2'b00, 2'b00, 12'h000, 16'h0000, g);
    chk("midrst_rvalid", 32'(rvalid), 0);

    // Idle.
    for (int k = 0; k < 10; k++) begin
      step(2'b00, 2'b00, 2'b00, 12'($urandom), 16'($urandom), g);
      chk("idle_gnt", 32'(g), 0);
    end

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 63) == 0) begin
        r_rnd = NREQ'($urandom_range(0, 3));
        do_reset(r_rnd);
      end else begin
        step(NREQ'($urandom_range(0, 3)), NREQ'($urandom_range(0, 3)),
             ($urandom_range(0, 2) == 0) ? NREQ'($urandom_range(0, 3)) : '0,
             12'($urandom), 16'($urandom), g);
      end
    end

    // Drain outstanding reads.
    for (int k = 0; k < 3; k++) step(2'b00, 2'b00, 2'b00, 12'h000, 16'h0000, g);
    chk("drain_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
